axis_rr_packet_merge: RTL and testbench

Parametrised N-to-1 AXI-Stream merger. It takes NUM slave streams and drives one master stream through a registered output stage. Arbitration is round-robin. In PACKET mode a granted channel holds the output until its tlast beat has been transferred; BEAT mode re-arbitrates on every beat. It sits between per-channel packet sources and a shared downstream consumer, and tags each output beat with its source channel index.

---
 rtl/axis_rr_packet_merge.sv | 84 ++++++++
 tb/tb_axis_rr_packet_merge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_packet_merge.sv
// axis_rr_packet_merge: round-robin N-to-1 AXI-Stream merger with optional packet lock.
// Output is a single register stage; each beat is tagged with its source channel.
module axis_rr_packet_merge #(
    parameter int NUM   = 4,
    parameter int DSIZE = 8,
    parameter     MODE  = "PACKET",
    parameter int CW    = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [NUM-1:0]         s_tvalid,
    output logic [NUM-1:0]         s_tready,
    input  logic [NUM*DSIZE-1:0]   s_tdata,
    input  logic [NUM-1:0]         s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DSIZE-1:0]       m_tdata,
    output logic                   m_tlast,
    output logic [CW-1:0]          m_tdest
);
    localparam bit BEAT = (MODE == "BEAT");
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_nx;
    logic [CW-1:0] ptr, ptr_nx, lock_ch, lock_nx, search, grant, grant_inc;
    logic found, has_grant, load, accept, acc_last;
    // Descending scan so the channel closest to ptr (in wrap order) wins.
    always_comb begin
        found  = 1'b0;
        search = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (s_tvalid[(int'(ptr) + k) % NUM]) begin
                found  = 1'b1;
                search = CW'((int'(ptr) + k) % NUM);
            end
        end
    end
    assign grant     = (state == LOCK) ? lock_ch : search;
    assign has_grant = (state == LOCK) || found;
    assign load      = !m_tvalid || m_tready;
    assign s_tready  = (load && has_grant && !rst) ? (NUM'(1) << grant) : '0;
    assign accept    = |(s_tvalid & s_tready);
    assign acc_last  = s_tlast[grant];
    assign grant_inc = (grant == CW'(NUM - 1)) ? '0 : grant + 1'b1;
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        lock_nx  = lock_ch;
        if (accept) begin
            if (BEAT || acc_last) begin
                state_nx = IDLE;
                ptr_nx   = grant_inc;
            end else if (state == IDLE) begin
                state_nx = LOCK;
                lock_nx  = grant;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            lock_ch <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            lock_ch <= lock_nx;
        end
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tdest  <= '0;
        end else if (load) begin
            m_tvalid <= accept;
            if (accept) begin
                m_tdata <= s_tdata[grant*DSIZE +: DSIZE];
                m_tlast <= acc_last;
                m_tdest <= grant;
            end
        end
    end
endmodule

// File: tb/tb_axis_rr_packet_merge.sv
// tb_axis_rr_packet_merge: PACKET and BEAT instances checked every cycle against a
// round-robin reference model, plus directed scenarios with literal expectations.
module tb_axis_rr_packet_merge;
    localparam int N = 4, W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0] sv [2], sr [2], sl [2];
    logic [N*W-1:0] sd [2];
    logic mv [2], mr [2], ml [2];
    logic [W-1:0] md [2];
    logic [1:0] mt [2];
    axis_rr_packet_merge #(.NUM(N), .DSIZE(W), .MODE("PACKET")) u_pkt (
        .clock(clk), .rst(rst), .s_tvalid(sv[0]), .s_tready(sr[0]), .s_tdata(sd[0]),
        .s_tlast(sl[0]), .m_tvalid(mv[0]), .m_tready(mr[0]), .m_tdata(md[0]),
        .m_tlast(ml[0]), .m_tdest(mt[0]));
    axis_rr_packet_merge #(.NUM(N), .DSIZE(W), .MODE("BEAT")) u_beat (
        .clock(clk), .rst(rst), .s_tvalid(sv[1]), .s_tready(sr[1]), .s_tdata(sd[1]),
        .s_tlast(sl[1]), .m_tvalid(mv[1]), .m_tready(mr[1]), .m_tdata(md[1]),
        .m_tlast(ml[1]), .m_tdest(mt[1]));
    int vectors = 0, miscompares = 0, cyc = 0;
    int rmode [2];
    logic mr_man [2];
    logic [8:0] qb [2][N][256];
    int qh [2][N], qt [2][N];
    logic [N-1:0] acc [2];
    logic [10:0] lg [2][1024];
    int lcy [2][1024];
    int lc [2];
    bit e_lock [2];
    int e_lch [2], e_ptr [2];
    logic e_v [2], e_l [2];
    logic [W-1:0] e_d [2];
    logic [1:0] e_t [2];
    int g_m;
    bit ld_m;
    logic [N-1:0] er_m;
    task automatic chk(string nm, int d, logic [31:0] a, logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", nm, d, a, e, cyc);
        end
    endtask
    // Reference arbitration: locked channel, else first requester from ptr in wrap order.
    function automatic int pick(int d);
        if (e_lock[d]) return e_lch[d];
        for (int k = 0; k < N; k++) if (sv[d][(e_ptr[d] + k) % N]) return (e_ptr[d] + k) % N;
        return -1;
    endfunction
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ld_m = !e_v[d] || mr[d];
            g_m  = pick(d);
            er_m = (rst || !ld_m || g_m < 0) ? 4'b0 : (4'b1 << g_m);
            chk("s_tready", d, 32'(sr[d]), 32'(er_m));
            chk("m_tvalid", d, 32'(mv[d]), 32'(e_v[d]));
            chk("m_tdata",  d, 32'(md[d]), 32'(e_d[d]));
            chk("m_tlast",  d, 32'(ml[d]), 32'(e_l[d]));
            chk("m_tdest",  d, 32'(mt[d]), 32'(e_t[d]));
            acc[d] = sv[d] & sr[d];
            if (mv[d] && mr[d] && !rst) begin
                lg[d][lc[d] % 1024]  = {mt[d], ml[d], md[d]};
                lcy[d][lc[d] % 1024] = cyc;
                lc[d]++;
            end
            if (rst) begin
                e_lock[d] = 0; e_lch[d] = 0; e_ptr[d] = 0;
                e_v[d] = 0; e_d[d] = '0; e_l[d] = 0; e_t[d] = '0;
            end else if (ld_m) begin
                if (g_m >= 0 && sv[d][g_m]) begin
                    e_v[d] = 1;
                    e_d[d] = sd[d][g_m*W +: W];
                    e_l[d] = sl[d][g_m];
                    e_t[d] = 2'(g_m);
                    if (d == 1 || sl[d][g_m]) begin
                        e_lock[d] = 0;
                        e_ptr[d]  = (g_m + 1) % N;
                    end else begin
                        e_lock[d] = 1;
                        e_lch[d]  = g_m;
                    end
                end else e_v[d] = 0;
            end
        end
        cyc++;
    end
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                if (acc[d][c]) qh[d][c]++;
                sv[d][c] = (qh[d][c] != qt[d][c]);
                {sl[d][c], sd[d][c*W +: W]} = qb[d][c][qh[d][c] % 256];
            end
            mr[d] = (rmode[d] == 1) ? ($urandom_range(0, 3) != 0) : (rmode[d] == 2) ? mr_man[d] : 1'b1;
        end
    end
    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask
    task automatic push(int d, int c, logic [7:0] dt, logic lst);
        qb[d][c][qt[d][c] % 256] = {lst, dt};
        qt[d][c]++;
    endtask
    task automatic pkt(int d, int c, int len);
        for (int i = 0; i < len; i++) push(d, c, 8'($urandom), i == len - 1);
    endtask
    function automatic bit busy();
        for (int d = 0; d < 2; d++) for (int c = 0; c < N; c++) if (qh[d][c] != qt[d][c]) return 1;
        return mv[0] || mv[1];
    endfunction
    task automatic drain(string nm);
        int t = 0;
        while (busy() && t < 300) begin tick(); t++; end
        chk(nm, 0, 32'(t >= 300), 32'(0));
    endtask
    function automatic logic [10:0] ent(int d, int i);
        return lg[d][i % 1024];
    endfunction
    initial begin
        int b0, b1, base, t;
        int exp3 [6] = '{1, 1, 1, 2, 3, 0};
        int exp5 [3] = '{3, 1, 3};
        logic [7:0] exp4 [3] = '{8'hA5, 8'h5A, 8'hFF};
        for (int d = 0; d < 2; d++) begin
            rmode[d] = 0; mr_man[d] = 1; acc[d] = '0; lc[d] = 0;
            e_lock[d] = 0; e_lch[d] = 0; e_ptr[d] = 0;
            e_v[d] = 0; e_d[d] = '0; e_l[d] = 0; e_t[d] = '0;
            for (int c = 0; c < N; c++) begin qh[d][c] = 0; qt[d][c] = 0; end
        end
        for (int d = 0; d < 2; d++) for (int c = 0; c < N; c++) push(d, c, 8'(16 * c + 1), 1);
        tick(3);
        chk("rst_ready", 0, 32'(sr[0]), 32'(0));
        chk("rst_ready", 1, 32'(sr[1]), 32'(0));
        chk("rst_mvalid", 0, 32'(mv[0]), 32'(0));
        chk("rst_mdest", 0, 32'(mt[0]), 32'(0));
        b0 = lc[0]; b1 = lc[1];
        rst = 0;
        drain("drain_reset");
        for (int i = 0; i < 4; i++) chk("post_rst_order", 0, 32'(ent(0, b0 + i) >> 9), 32'(i));
        chk("post_rst_first", 1, 32'(ent(1, b1) >> 9), 32'(0));
        b1 = lc[1];
        for (int c = 0; c < N; c++) pkt(1, c, 2);
        drain("drain_beat");
        for (int i = 0; i < 6; i++) chk("beat_rr", 1, 32'(ent(1, b1 + i) >> 9), 32'(i % 4));
        chk("beat_nobubble", 1, 32'(lcy[1][(b1 + 5) % 1024] - lcy[1][b1 % 1024]), 32'(5));
        push(0, 0, 8'h11, 1);
        drain("drain_pre_lock");
        b0 = lc[0];
        pkt(0, 1, 3);
        push(0, 0, 8'h20, 1); push(0, 2, 8'h22, 1); push(0, 3, 8'h23, 1);
        drain("drain_lock");
        for (int i = 0; i < 6; i++) chk("lock_order", 0, 32'(ent(0, b0 + i) >> 9), 32'(exp3[i]));
        chk("lock_mid_last", 0, 32'(ent(0, b0 + 1) >> 8 & 1), 32'(0));
        chk("lock_end_last", 0, 32'(ent(0, b0 + 2) >> 8 & 1), 32'(1));
        b0 = lc[0];
        rmode[0] = 2;
        push(0, 2, 8'hA5, 0); push(0, 2, 8'h5A, 0); push(0, 2, 8'hFF, 1);
        mr_man[0] = 1; tick();
        mr_man[0] = 0; tick();
        mr_man[0] = 0; tick();
        mr_man[0] = 1; tick();
        rmode[0] = 0;
        drain("drain_bp");
        chk("bp_count", 0, 32'(lc[0] - b0), 32'(3));
        for (int i = 0; i < 3; i++) chk("bp_data", 0, 32'(ent(0, b0 + i) & 11'hFF), 32'(exp4[i]));
        b0 = lc[0];
        push(0, 1, 8'h31, 1); push(0, 3, 8'h33, 1); push(0, 3, 8'h34, 1);
        drain("drain_wrap");
        for (int i = 0; i < 3; i++) chk("wrap_order", 0, 32'(ent(0, b0 + i) >> 9), 32'(exp5[i]));
        base = qh[0][3];
        push(0, 3, 8'hC1, 0); push(0, 3, 8'hC2, 0); push(0, 3, 8'hC3, 0); push(0, 3, 8'hC4, 1);
        t = 0;
        while (qh[0][3] - base < 2 && t < 50) begin tick(); t++; end
        chk("midpkt_wait", 0, 32'(t >= 50), 32'(0));
        rst = 1;
        push(0, 0, 8'h40, 1);
        tick();
        rst = 0;
        chk("mvalid_after_rst", 0, 32'(mv[0]), 32'(0));
        b0 = lc[0];
        drain("drain_midpkt");
        chk("midpkt_first", 0, 32'(ent(0, b0) >> 9), 32'(0));
        chk("midpkt_resume", 0, 32'(ent(0, b0 + 1)), 32'({2'd3, 1'b0, 8'hC3}));
        chk("midpkt_count", 0, 32'(lc[0] - b0), 32'(3));
        rmode[0] = 1; rmode[1] = 1;
        repeat (3000) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < N; c++)
                    if (qt[d][c] - qh[d][c] < 4 && $urandom_range(0, 9) == 0) pkt(d, c, $urandom_range(1, 5));
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        rmode[0] = 0; rmode[1] = 0;
        drain("drain_random");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
